// File: rtl/cc_pkg.sv
// Shared constants for the cross-correlation run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_pkg;

    // Default build-time geometry
    localparam int CC_ADDR_W      = 18;
    localparam int CC_IDX_W       = 10;
    localparam int CC_N_SAMPLES   = 12800;
    localparam int CC_TIMEOUT_CYC = 1048576;

    // Sequencer state encoding (plain constants so older tools can consume them)
    typedef logic [2:0] cc_state_t;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_RESULT = 3'd5;

    // Lag index reported when the core never answers: most-negative value
    localparam logic [CC_IDX_W-1:0] CC_ERR_INDEX = {1'b1, {(CC_IDX_W-1){1'b0}}};

    // Same error pattern for an arbitrary index width (sign bit only)
    function automatic logic [31:0] cc_err_index(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/cc_addr_gen.sv
// Sample-memory address counter: clear, load, increment, terminal-count flag at N_SAMPLES-1.
// Latency: address updates one cycle after clr/load/inc; tc is combinational from the address.
// Backpressure: none; the caller stops incrementing when tc is seen.
module cc_addr_gen
    import cc_pkg::*;
#(
    parameter int ADDR_W    = CC_ADDR_W,
    parameter int N_SAMPLES = CC_N_SAMPLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    // Counter register; clear wins over load, load wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (inc) begin
            addr <= addr + 1'b1;
        end
    end

    assign tc = (addr == LAST_ADDR);

endmodule

// File: rtl/cc_sequencer.sv
// Runs one cross-correlation core pass per req: core reset, start, N_SAMPLES-cycle address sweep, wait for done, hand off lag index.
// Latency: req->ack 1 cycle, ack->cc_start 2 cycles, sample k reaches the core k cycles after cc_start.
// Backpressure: result held on res_valid/res_index until res_ready; new req ignored until back in IDLE. Optional CC_WATCHDOG_EN adds a WAIT timeout (err + forced index).
module cc_sequencer
    import cc_pkg::*;
#(
    parameter int N_SAMPLES   = CC_N_SAMPLES,
    parameter int ADDR_W      = CC_ADDR_W,
    parameter int IDX_W       = CC_IDX_W,
    parameter int TIMEOUT_CYC = CC_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              cc_rst,
    output logic              cc_start,
    input  logic              cc_done,
    input  logic [IDX_W-1:0]  cc_index,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_index,
    output logic              busy,
    output logic              err
);

    cc_state_t state;
    logic      addr_inc;
    logic      addr_tc;

`ifdef CC_WATCHDOG_EN
    localparam int                WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  ERR_INDEX = IDX_W'(cc_err_index(IDX_W));
    logic [WD_W-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Address advances through START and STREAM, parks at 0 everywhere else,
    // so address N_SAMPLES is never presented.
    assign addr_inc = (state == ST_START) || ((state == ST_STREAM) && !addr_tc);

    cc_addr_gen #(
        .ADDR_W    (ADDR_W),
        .N_SAMPLES (N_SAMPLES)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (!addr_inc),
        .load     (1'b0),
        .load_val ('0),
        .inc      (addr_inc),
        .addr     (mem_addr),
        .tc       (addr_tc)
    );

    // Control state, accept pulse, captured index and sticky timeout flag.
    // IDLE spends the ack cycle itself, which gives the 2-cycle ack->start gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ack       <= 1'b0;
            res_index <= '0;
`ifdef CC_WATCHDOG_EN
            err       <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ack) begin
                        state <= ST_CLEAR;
                    end else if (req) begin
                        ack <= 1'b1;
`ifdef CC_WATCHDOG_EN
                        err <= 1'b0;
`endif
                    end
                end
                ST_CLEAR:  state <= ST_START;
                ST_START:  state <= ST_STREAM;
                ST_STREAM: begin
                    // cc_done is deliberately not looked at while streaming
                    if (addr_tc) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cc_done) begin
                        res_index <= cc_index;
                        state     <= ST_RESULT;
                    end
`ifdef CC_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        res_index <= ERR_INDEX;
                        err       <= 1'b1;
                        state     <= ST_RESULT;
                    end
`endif
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CC_WATCHDOG_EN
    // WAIT-cycle counter: 0 on the first WAIT cycle, held at 0 elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign cc_rst    = (state == ST_CLEAR);
    assign cc_start  = (state == ST_START);
    assign res_valid = (state == ST_RESULT);
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/cc_sequencer.md
Name: cc_sequencer

Overview:
- Controller that sequences one cross-correlation core run per request.
- Sequence per run: pulse the core's reset, pulse start, sweep the shared sample-memory address over N_SAMPLES consecutive cycles, wait for the core's done, capture the signed lag index, then present it on a valid/ready result port.
- Sits between the frame-capture logic (requester) and the cross-correlation core plus its two sample memories.

Parameters:
- N_SAMPLES, 12800, samples streamed per run (at least 2).
- ADDR_W, 18, sample-memory address width.
- IDX_W, 10, signed lag index width.
- TIMEOUT_CYC, 1048576, maximum WAIT cycles before error (watchdog only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  frame ready in both sample memories; level, sampled in IDLE.
- ack  out  1  one-cycle pulse: request accepted, memories now owned by the sequencer.
- mem_addr  out  ADDR_W  read address shared by both sample memories (combinational read).
- cc_rst  out  1  reset to the core.
- cc_start  out  1  start pulse to the core.
- cc_done  in  1  core finished; level.
- cc_index  in  IDX_W  core result, signed two's complement; valid while cc_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_index  out  IDX_W  latched lag index.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared only by rst or on the next accepted req.

Behaviour:
- Reset values: all outputs 0, state IDLE, mem_addr 0. rst aborts any state immediately, including mid-stream.
- States and transitions:
  - IDLE: if req=1, pulse ack and go to CLEAR.
  - CLEAR: cc_rst=1 for exactly 1 cycle; go to START.
  - START: cc_start=1 for 1 cycle with mem_addr=0; go to STREAM.
  - STREAM: mem_addr increments by 1 each cycle. When mem_addr reaches N_SAMPLES-1, hold it that cycle, then go to WAIT. Address N_SAMPLES is never driven.
  - WAIT: mem_addr returns to 0. When cc_done=1, latch cc_index into res_index and go to RESULT.
  - RESULT: res_valid=1 and res_index held stable until res_valid&&res_ready. On that handshake, res_valid drops the next cycle and the state returns to IDLE.
- Timing: the core sees sample k exactly k cycles after the cc_start cycle. Streaming occupies exactly N_SAMPLES cycles (START plus N_SAMPLES-1 STREAM cycles).
- Latency: req to first ack is 1 cycle. ack to cc_start is 2 cycles.
- cc_done=1 during STREAM is ignored. Only WAIT samples cc_done.
- req held high in RESULT is not accepted until the block is back in IDLE. Back-to-back runs have at least 1 IDLE cycle between them.
- res_ready high before res_valid has no effect.
- cc_index is passed through unmodified; no arithmetic on it. The address counter is unsigned and never wraps.

Optional Feature:
- Macro: CC_WATCHDOG_EN.
- Defined: a WAIT-cycle counter starts at 0 on WAIT entry. If it reaches TIMEOUT_CYC with cc_done=0:
  - err is set;
  - res_index is forced to the most-negative value (sign bit 1, all other bits 0);
  - the block enters RESULT normally.
- Not defined: no counter is built, err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Package cc_pkg holds:
  - the state encoding IDLE/CLEAR/START/STREAM/WAIT/RESULT;
  - the default widths (ADDR_W, IDX_W);
  - the default N_SAMPLES;
  - the error index constant.
- One sub-module, cc_addr_gen: a loadable, clear-able up-counter with a terminal-count flag at N_SAMPLES-1, used for mem_addr.
- The watchdog counter stays inline.

Test Plan:
- N_SAMPLES=16. Assert rst for 2 cycles, then req=1 -> ack 1 cycle later; cc_rst 1 cycle; cc_start with mem_addr=0; mem_addr 1..15 on consecutive cycles; mem_addr=0 in WAIT.
- Model core asserts cc_done with cc_index=-25 (0x3E7) 40 cycles after start, res_ready=1 -> res_valid for 1 cycle, res_index=0x3E7, busy falls.
- res_ready held low 10 cycles in RESULT while cc_index changes to 5 -> res_index stays 0x3E7 and res_valid stays high until the handshake.
- rst asserted with mem_addr=7 in STREAM -> all outputs 0 immediately. A following req restarts at CLEAR with mem_addr sweeping from 0.
- cc_done pulsed at mem_addr=3 during STREAM -> ignored; a later cc_done in WAIT with cc_index=12 -> res_index=12.
- CC_WATCHDOG_EN, TIMEOUT_CYC=32, cc_done never asserted -> err=1 and res_index=0x200 exactly 32 cycles after WAIT entry. The next accepted req clears err.
